// File: rtl/dbg_pkg.sv
// Shared definitions for the capture readout path.
//   rd_state_t   : readout FSM state encoding
//   RD_BUF_DEPTH : entries in the readout output buffer
//   RD_OCC_W     : width of the buffer occupancy count
package dbg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rd_state_t;

  localparam int unsigned RD_BUF_DEPTH = 2;
  localparam int unsigned RD_OCC_W     = 2;

endpackage

// File: rtl/rd_addr_ctrl_if.sv
// RAM read port plus output stream of the readout stage.
//   ram_rd_en/ram_rd_addr : read strobe and address towards the capture RAM
//   ram_rd_data           : RAM data, one cycle after the strobe
//   rd_data/rd_data_vld/rd_data_rdy/rd_last : valid/ready word stream
// master = readout controller, slave = RAM + stream consumer.
interface rd_addr_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 14
);

  logic                  ram_rd_en;
  logic [ADDR_WIDTH-1:0] ram_rd_addr;
  logic [DATA_WIDTH-1:0] ram_rd_data;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_data_vld;
  logic                  rd_data_rdy;
  logic                  rd_last;

  modport master (
    output ram_rd_en,
    output ram_rd_addr,
    input  ram_rd_data,
    output rd_data,
    output rd_data_vld,
    input  rd_data_rdy,
    output rd_last
  );

  modport slave (
    input  ram_rd_en,
    input  ram_rd_addr,
    output ram_rd_data,
    input  rd_data,
    input  rd_data_vld,
    output rd_data_rdy,
    input  rd_last
  );

endinterface

// File: rtl/rd_skid_buf.sv
// Two-entry valid/ready buffer with registered head.
//   clk, rst_n          : clock, async active-low reset
//   flush               : drop all stored entries (and the incoming one)
//   in_vld, in_data     : push side; the caller guarantees a free slot
//   out_vld, out_data   : head entry, held stable until out_rdy
//   out_rdy             : consumer accepts the head entry
//   occupancy           : number of stored entries (0..2)
module rd_skid_buf
  import dbg_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_vld,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_vld,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_rdy,
  output logic [RD_OCC_W-1:0]   occupancy
);

  logic                  head_vld_q, head_vld_d;
  logic                  tail_vld_q, tail_vld_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;

  // Pop first (tail moves to head), then place the push in the first free slot.
  always_comb begin
    head_vld_d = head_vld_q;
    tail_vld_d = tail_vld_q;
    head_d     = head_q;
    tail_d     = tail_q;
    if (flush) begin
      head_vld_d = 1'b0;
      tail_vld_d = 1'b0;
    end else begin
      if (out_rdy && head_vld_q) begin
        head_vld_d = tail_vld_q;
        head_d     = tail_q;
        tail_vld_d = 1'b0;
      end
      if (in_vld) begin
        if (!head_vld_d) begin
          head_vld_d = 1'b1;
          head_d     = in_data;
        end else begin
          tail_vld_d = 1'b1;
          tail_d     = in_data;
        end
      end
    end
  end

  // Storage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_vld_q <= 1'b0;
      tail_vld_q <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      head_vld_q <= head_vld_d;
      tail_vld_q <= tail_vld_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

  assign out_vld   = head_vld_q;
  assign out_data  = head_q;
  assign occupancy = RD_OCC_W'(head_vld_q) + RD_OCC_W'(tail_vld_q);

endmodule

// File: rtl/rd_addr_ctrl.sv
// Capture RAM readout controller: after a completed capture, reads the RAM
// in chronological order (start .. max, wrapping to 0) and streams the words.
//   clk, rst_n        : clock, async active-low reset
//   rd_start          : readout request, honoured only in IDLE with tri_done=1
//   rd_abort          : terminate readout, flush buffered and in-flight data
//   tri_done          : capture complete flag from the write controller
//   read_start_addr   : oldest sample address (latched at start)
//   capture_max_addr  : last RAM address in use (latched at start)
//   bus               : RAM read port and output stream (master side)
//   tri_done_rd       : one-cycle pulse when a readout completes normally
//   rd_busy           : readout in progress
module rd_addr_ctrl
  import dbg_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 14,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_start,
  input  logic                  rd_abort,
  input  logic                  tri_done,
  input  logic [ADDR_WIDTH-1:0] read_start_addr,
  input  logic [ADDR_WIDTH-1:0] capture_max_addr,
  rd_addr_ctrl_if.master        bus,
  output logic                  tri_done_rd,
  output logic                  rd_busy
);

  localparam int unsigned CNT_W  = ADDR_WIDTH + 1;
  localparam int unsigned INF_W  = $clog2(RD_LATENCY + 1);
  localparam int unsigned USED_W = INF_W + RD_OCC_W;

  rd_state_t               state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, max_q;
  logic [CNT_W-1:0]        total_q, issued_q, delivered_q;
  logic [RD_LATENCY-1:0]   inflight_q;
  logic [INF_W-1:0]        inflight_cnt;
  logic [USED_W-1:0]       used_c;
  logic [RD_OCC_W-1:0]     occ;
  logic                    buf_vld;
  logic [DATA_WIDTH-1:0]   buf_data;
  logic                    pop_c, issue_c, accept_c;

  // Reads still travelling through the RAM pipeline.
  always_comb begin
    inflight_cnt = '0;
    for (int i = 0; i < int'(RD_LATENCY); i++) begin
      inflight_cnt = inflight_cnt + INF_W'(inflight_q[i]);
    end
  end

  // Slots already claimed in the buffer; a slot vacated by this cycle's pop
  // counts as free, which is what allows one word per cycle.
  assign pop_c  = buf_vld & bus.rd_data_rdy;
  assign used_c = USED_W'(occ) - USED_W'(pop_c) + USED_W'(inflight_cnt);

  // FSM next state and read issue.
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    issue_c  = 1'b0;
    if (rd_abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (rd_start && tri_done) begin
            accept_c = 1'b1;
            state_d  = READ;
          end
        end
        READ: begin
          if (issued_q < total_q) begin
            issue_c = (used_c < USED_W'(RD_BUF_DEPTH));
          end else begin
            state_d = DRAIN;
          end
        end
        DRAIN: begin
          if (delivered_q == total_q) state_d = DONE;
        end
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Address generator and transfer counters; config is latched at accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= '0;
      max_q       <= '0;
      total_q     <= '0;
      issued_q    <= '0;
      delivered_q <= '0;
    end else if (accept_c) begin
      addr_q      <= (read_start_addr > capture_max_addr) ? '0 : read_start_addr;
      max_q       <= capture_max_addr;
      total_q     <= CNT_W'(capture_max_addr) + CNT_W'(1);
      issued_q    <= '0;
      delivered_q <= '0;
    end else if (rd_abort) begin
      issued_q    <= '0;
      delivered_q <= '0;
    end else begin
      if (issue_c) begin
        issued_q <= issued_q + CNT_W'(1);
        addr_q   <= (addr_q == max_q) ? '0 : addr_q + ADDR_WIDTH'(1);
      end
      if (pop_c) delivered_q <= delivered_q + CNT_W'(1);
    end
  end

  // Read-latency pipeline; the oldest bit marks RAM data arriving this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        inflight_q <= '0;
    else if (rd_abort) inflight_q <= '0;
    else               inflight_q <= RD_LATENCY'({inflight_q, issue_c});
  end

  rd_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (rd_abort),
    .in_vld    (inflight_q[RD_LATENCY-1]),
    .in_data   (bus.ram_rd_data),
    .out_vld   (buf_vld),
    .out_data  (buf_data),
    .out_rdy   (bus.rd_data_rdy),
    .occupancy (occ)
  );

  assign bus.ram_rd_en   = issue_c;
  assign bus.ram_rd_addr = addr_q;
  assign bus.rd_data     = buf_data;
  assign bus.rd_data_vld = buf_vld;
  assign bus.rd_last     = buf_vld && (delivered_q == total_q - CNT_W'(1));
  assign tri_done_rd     = (state_q == DONE);
  assign rd_busy         = (state_q != IDLE);

endmodule

// File: tb/tb_rd_addr_ctrl.sv
// Directed bench for rd_addr_ctrl: RAM model returns 0xC0DE0000 | addr,
// a negedge monitor logs reads, stream transfers and pulses.
module tb_rd_addr_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_start, rd_abort, tri_done;
  logic [13:0] rsa, cma;
  logic        tri_done_rd, rd_busy;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int start_cyc;

  rd_addr_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(14)) bus ();

  rd_addr_ctrl #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (14),
    .RD_LATENCY (1)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .rd_start         (rd_start),
    .rd_abort         (rd_abort),
    .tri_done         (tri_done),
    .read_start_addr  (rsa),
    .capture_max_addr (cma),
    .bus              (bus),
    .tri_done_rd      (tri_done_rd),
    .rd_busy          (rd_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model, 1-cycle read latency
  always @(posedge clk) begin
    if (bus.ram_rd_en) bus.ram_rd_data <= 32'hC0DE_0000 | 32'(bus.ram_rd_addr);
  end

  // Monitor
  logic [13:0] addr_log[$];
  logic [31:0] data_log[$];
  bit          last_log[$];
  logic        clr_log;
  int          done_pulses, busy_cycles, stall_viol, max_occ;
  int          first_en_cyc, first_vld_cyc, last_vld_cyc;
  logic        prev_stall;
  logic [31:0] prev_data;

  always @(negedge clk) begin
    if (clr_log) begin
      addr_log.delete();
      data_log.delete();
      last_log.delete();
      done_pulses   <= 0;
      busy_cycles   <= 0;
      stall_viol    <= 0;
      max_occ       <= 0;
      first_en_cyc  <= -1;
      first_vld_cyc <= -1;
      last_vld_cyc  <= -1;
      prev_stall    <= 1'b0;
    end else if (rst_n) begin
      if (bus.ram_rd_en) begin
        addr_log.push_back(bus.ram_rd_addr);
        if (first_en_cyc < 0) first_en_cyc <= cyc;
      end
      if (bus.rd_data_vld && first_vld_cyc < 0) first_vld_cyc <= cyc;
      if (bus.rd_data_vld && bus.rd_data_rdy) begin
        data_log.push_back(bus.rd_data);
        last_log.push_back(bus.rd_last);
        last_vld_cyc <= cyc;
      end
      if (prev_stall && !(bus.rd_data_vld && bus.rd_data === prev_data))
        stall_viol <= stall_viol + 1;
      prev_stall <= bus.rd_data_vld && !bus.rd_data_rdy;
      prev_data  <= bus.rd_data;
      if (tri_done_rd) done_pulses <= done_pulses + 1;
      if (rd_busy) busy_cycles <= busy_cycles + 1;
      if (int'(dut.u_buf.occupancy) > max_occ) max_occ <= int'(dut.u_buf.occupancy);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    clr_log = 1'b1;
    @(negedge clk);
    #1 clr_log = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic start_readout(input logic [13:0] st, input logic [13:0] mx);
    rsa       = st;
    cma       = mx;
    rd_start  = 1'b1;
    start_cyc = cyc;
    step(1);
    rd_start  = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget, input bit rnd);
    int n;
    n = 0;
    while (rd_busy && n < budget) begin
      if (rnd) bus.rd_data_rdy = 1'($urandom_range(0, 1));
      step(1);
      n++;
    end
    bus.rd_data_rdy = 1'b1;
    chk({tag, "_timeout"}, 32'(rd_busy), 32'd0);
    step(1);
  endtask

  task automatic check_run(input string tag, input int unsigned st, input int unsigned mx);
    int unsigned n;
    int unsigned exp_a;
    int bad_a, bad_d, bad_l;
    n = mx + 1;
    bad_a = 0; bad_d = 0; bad_l = 0;
    chk({tag, "_n_reads"}, 32'(addr_log.size()), 32'(n));
    chk({tag, "_n_words"}, 32'(data_log.size()), 32'(n));
    for (int unsigned i = 0; i < n; i++) begin
      exp_a = (st + i) % n;
      if (i < 32'(addr_log.size()) && addr_log[i] !== 14'(exp_a)) bad_a++;
      if (i < 32'(data_log.size())) begin
        if (data_log[i] !== (32'hC0DE_0000 | exp_a)) bad_d++;
        if (last_log[i] != (i == n - 1)) bad_l++;
      end
    end
    chk({tag, "_addr_seq"}, 32'(bad_a), 32'd0);
    chk({tag, "_data_seq"}, 32'(bad_d), 32'd0);
    chk({tag, "_last"}, 32'(bad_l), 32'd0);
    chk({tag, "_done_pulse"}, 32'(done_pulses), 32'd1);
    chk({tag, "_stall_stable"}, 32'(stall_viol), 32'd0);
    chk({tag, "_occ_le2"}, 32'(max_occ <= 2), 32'd1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; rd_start = 1'b0; rd_abort = 1'b0; tri_done = 1'b0;
    rsa = '0; cma = '0; bus.rd_data_rdy = 1'b1; clr_log = 1'b0;
    step(3);
    chk("rst_ram_rd_en", 32'(bus.ram_rd_en), 32'd0);
    chk("rst_vld",       32'(bus.rd_data_vld), 32'd0);
    chk("rst_busy",      32'(rd_busy), 32'd0);
    chk("rst_done_rd",   32'(tri_done_rd), 32'd0);
    chk("rst_last",      32'(bus.rd_last), 32'd0);
    chk("rst_addr",      32'(bus.ram_rd_addr), 32'd0);
    chk("rst_data",      bus.rd_data, 32'd0);
    rst_n = 1'b1;
    step(2);

    // normal run
    tri_done = 1'b1;
    clear_logs();
    start_readout(14'd5, 14'd7);
    wait_idle("normal", 100, 1'b0);
    chk("lat_ram_rd_en", 32'(first_en_cyc - start_cyc), 32'd1);
    chk("lat_vld",       32'(first_vld_cyc - start_cyc), 32'd3);
    chk("throughput",    32'(last_vld_cyc - first_vld_cyc), 32'd7);
    check_run("normal", 5, 7);

    // gating: no tri_done
    tri_done = 1'b0;
    clear_logs();
    start_readout(14'd5, 14'd7);
    step(5);
    chk("gate_no_reads", 32'(addr_log.size()), 32'd0);
    chk("gate_not_busy", 32'(busy_cycles), 32'd0);

    // second rd_start while busy is ignored
    tri_done = 1'b1;
    clear_logs();
    start_readout(14'd5, 14'd7);
    step(3);
    rsa = 14'd0; cma = 14'd3; rd_start = 1'b1;
    step(1);
    rd_start = 1'b0;
    wait_idle("dbl", 100, 1'b0);
    check_run("dbl", 5, 7);

    // backpressure
    clear_logs();
    start_readout(14'd5, 14'd7);
    wait_idle("bp", 400, 1'b1);
    check_run("bp", 5, 7);

    // abort after 3 words
    clear_logs();
    start_readout(14'd5, 14'd7);
    n = 0;
    while (data_log.size() < 3 && n < 50) begin
      step(1);
      n++;
    end
    rd_abort = 1'b1;
    step(1);
    rd_abort = 1'b0;
    chk("abort_busy",   32'(rd_busy), 32'd0);
    chk("abort_vld",    32'(bus.rd_data_vld), 32'd0);
    chk("abort_rd_en",  32'(bus.ram_rd_en), 32'd0);
    step(5);
    chk("abort_no_pulse", 32'(done_pulses), 32'd0);
    clear_logs();
    start_readout(14'd5, 14'd7);
    wait_idle("restart", 100, 1'b0);
    check_run("restart", 5, 7);

    // single word
    clear_logs();
    start_readout(14'd0, 14'd0);
    wait_idle("max0", 100, 1'b0);
    check_run("max0", 0, 0);

    // start beyond max, config changed mid-readout
    clear_logs();
    start_readout(14'd9, 14'd7);
    rsa = 14'd3; cma = 14'd2;
    wait_idle("wrap0", 100, 1'b0);
    check_run("wrap0", 0, 7);

    // start equals max
    clear_logs();
    start_readout(14'd7, 14'd7);
    wait_idle("stmax", 100, 1'b0);
    check_run("stmax", 7, 7);

    // async reset mid-READ
    clear_logs();
    start_readout(14'd5, 14'd7);
    step(2);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_ram_rd_en", 32'(bus.ram_rd_en), 32'd0);
    chk("arst_vld",       32'(bus.rd_data_vld), 32'd0);
    chk("arst_busy",      32'(rd_busy), 32'd0);
    chk("arst_done_rd",   32'(tri_done_rd), 32'd0);
    chk("arst_last",      32'(bus.rd_last), 32'd0);
    chk("arst_addr",      32'(bus.ram_rd_addr), 32'd0);
    chk("arst_data",      bus.rd_data, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(2);
    chk("arst_idle", 32'(rd_busy), 32'd0);
    chk("arst_no_pulse", 32'(done_pulses), 32'd0);
    clear_logs();
    start_readout(14'd5, 14'd7);
    wait_idle("post_rst", 100, 1'b0);
    check_run("post_rst", 5, 7);

    // full-size RAM
    clear_logs();
    start_readout(14'd100, 14'h3FFF);
    wait_idle("big", 20000, 1'b0);
    check_run("big", 100, 16383);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
